// File: rtl/post_adder_preg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : post_adder_preg                                                 |
// | Purpose  : DSP48A1-style post-adder/accumulator with optional P, carryout  |
// |            and opmode registers. POST_ADDER_PATTERN_DETECT_EN adds a       |
// |            PATTERN parameter and a patterndetect output.                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module post_adder_preg #(
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1,
  parameter int OPMODEREG   = 1
`ifdef POST_ADDER_PATTERN_DETECT_EN
  ,
  parameter logic [47:0] PATTERN = 48'd0
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_opmode,
  input  logic        ce_p,
  input  logic        ce_carryout,
  input  logic [5:0]  opmode,
  input  logic [35:0] m,
  input  logic [47:0] dab,
  input  logic [47:0] c,
  input  logic [47:0] pcin,
  output logic [47:0] p,
  output logic [47:0] pcout,
  output logic        carryout,
  output logic        carryoutf
`ifdef POST_ADDER_PATTERN_DETECT_EN
  ,
  output logic        patterndetect
`endif
);

  localparam logic [1:0] C_X_ZERO = 2'd0;
  localparam logic [1:0] C_X_M    = 2'd1;
  localparam logic [1:0] C_X_P    = 2'd2;
  localparam logic [1:0] C_X_DAB  = 2'd3;

  localparam logic [1:0] C_Z_ZERO = 2'd0;
  localparam logic [1:0] C_Z_PCIN = 2'd1;
  localparam logic [1:0] C_Z_P    = 2'd2;
  localparam logic [1:0] C_Z_C    = 2'd3;

  logic [5:0]  w_op;
  logic [47:0] w_p_fb;
  logic [47:0] w_x;
  logic [47:0] w_z;
  logic [48:0] w_cin_ext;
  logic [48:0] w_sum;

  // ---------------------------------------------------------------------------
  // Opmode capture
  // ---------------------------------------------------------------------------
  generate
    if (OPMODEREG != 0) begin : g_opmode_reg
      logic [5:0] r_op;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_op <= '0;
        end else if (ce_opmode) begin
          r_op <= opmode;
        end
      end
      assign w_op = r_op;
    end else begin : g_opmode_bypass
      logic unused_ce_opmode;
      assign unused_ce_opmode = ce_opmode;
      assign w_op             = opmode;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Operand muxes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_x = '0;
    case (w_op[1:0])
      C_X_ZERO: w_x = '0;
      C_X_M:    w_x = {12'd0, m};
      C_X_P:    w_x = w_p_fb;
      C_X_DAB:  w_x = dab;
      default:  w_x = '0;
    endcase
  end

  always_comb begin
    w_z = '0;
    case (w_op[3:2])
      C_Z_ZERO: w_z = '0;
      C_Z_PCIN: w_z = pcin;
      C_Z_P:    w_z = w_p_fb;
      C_Z_C:    w_z = c;
      default:  w_z = '0;
    endcase
  end

  // Carry-in joins X before the subtract so that Z - (X + cin) borrows as one op.
  assign w_cin_ext = {48'd0, w_op[4]};

  always_comb begin
    if (w_op[5]) begin
      w_sum = {1'b0, w_z} - ({1'b0, w_x} + w_cin_ext);
    end else begin
      w_sum = {1'b0, w_z} + {1'b0, w_x} + w_cin_ext;
    end
  end

  // ---------------------------------------------------------------------------
  // P stage (feedback is tied off when unregistered to avoid a comb loop)
  // ---------------------------------------------------------------------------
  generate
    if (PREG != 0) begin : g_p_reg
      logic [47:0] r_p;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_p <= '0;
        end else if (ce_p) begin
          r_p <= w_sum[47:0];
        end
      end
      assign p      = r_p;
      assign w_p_fb = r_p;
`ifdef POST_ADDER_PATTERN_DETECT_EN
      logic r_pd;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_pd <= 1'b0;
        end else if (ce_p) begin
          r_pd <= (w_sum[47:0] == PATTERN);
        end
      end
      assign patterndetect = r_pd;
`endif
    end else begin : g_p_bypass
      logic unused_ce_p;
      assign unused_ce_p = ce_p;
      assign p           = w_sum[47:0];
      assign w_p_fb      = '0;
`ifdef POST_ADDER_PATTERN_DETECT_EN
      assign patterndetect = (w_sum[47:0] == PATTERN);
`endif
    end
  endgenerate

  assign pcout = p;

  // ---------------------------------------------------------------------------
  // Carryout stage
  // ---------------------------------------------------------------------------
  generate
    if (CARRYOUTREG != 0) begin : g_carry_reg
      logic r_carry;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_carry <= 1'b0;
        end else if (ce_carryout) begin
          r_carry <= w_sum[48];
        end
      end
      assign carryout = r_carry;
    end else begin : g_carry_bypass
      logic unused_ce_carryout;
      assign unused_ce_carryout = ce_carryout;
      assign carryout           = w_sum[48];
    end
  endgenerate

  assign carryoutf = carryout;

endmodule
`default_nettype wire

// File: doc/post_adder_preg.md
Name: post_adder_preg

Overview:
- Post-adder / accumulator stage of the DSP48A1 slice.
- Sits directly downstream of the M (multiplier) pipeline register stage. Consumes the 36-bit product M, the concatenated D:A:B word, C, and the cascade input PCIN.
- Produces the 48-bit P output, the PCOUT cascade, and CARRYOUT/CARRYOUTF.
- Holds the P, CARRYOUT and OPMODE registers, each optionally bypassed, so accumulation feedback (P into the X/Z muxes) lives here.

Parameters:
- PREG, 1: 1 = P output registered; 0 = P combinational from the post-adder.
- CARRYOUTREG, 1: 1 = carryout registered; 0 = combinational.
- OPMODEREG, 1: 1 = opmode captured in a register before decode; 0 = decoded directly.

Ports:
- clk  in  1  single clock; all registers on its rising edge.
- rst  in  1  reset, asynchronous, active-low; clears every register in the block.
- ce_opmode  in  1  clock enable for the opmode register.
- ce_p  in  1  clock enable for the P register.
- ce_carryout  in  1  clock enable for the carryout register.
- opmode  in  6  [1:0] X select, [3:2] Z select, [4] carry-in, [5] subtract.
- m  in  36  product from the M stage.
- dab  in  48  concatenated {D[11:0],A[17:0],B[17:0]}.
- c  in  48  C operand.
- pcin  in  48  P cascade input.
- p  out  48  post-adder result.
- pcout  out  48  copy of p for cascade.
- carryout  out  1  carry/borrow out of bit 47.
- carryoutf  out  1  fabric copy of carryout.

Behaviour:
- Reset: when rst=0, asynchronously clear P, carryout and opmode registers to 0. rst low dominates every ce. Registers resume on the first rising clk edge after rst goes high.
- Opmode path:
  - OPMODEREG=1: op_q <= opmode when ce_opmode=1, else hold.
  - OPMODEREG=0: op_q = opmode.
  - Latency from opmode change to the X/Z select taking effect is 1 cycle when registered, 0 when bypassed.
- X mux on op_q[1:0]:
  - 0 = 48'd0
  - 1 = {12'd0, m} (zero-extended)
  - 2 = P
  - 3 = dab
- Z mux on op_q[3:2]:
  - 0 = 48'd0
  - 1 = pcin
  - 2 = P
  - 3 = c
- Arithmetic, 49-bit unsigned:
  - op_q[5]=0: sum = Z + X + cin.
  - op_q[5]=1: sum = Z - (X + cin).
  - cin = op_q[4].
  - Result = sum[47:0]; carry = sum[48]. On subtract, carry=1 means borrow.
  - Wrap-around is modular 2^48; there is no saturation.
- P register:
  - PREG=1: P <= result when ce_p=1, else hold.
  - PREG=0: P = result.
  - Feedback "P" in the X/Z muxes is always the P register output.
  - With PREG=0, the feedback P source reads 48'd0, so no combinational loop is created.
- Carryout register:
  - CARRYOUTREG=1: carryout <= carry when ce_carryout=1, else hold.
  - CARRYOUTREG=0: combinational.
  - carryoutf == carryout at all times.
- Output p: pcout == p at all times.
- Latency with PREG=1: inputs sampled at edge N appear on p after edge N, i.e. 1 cycle. With PREG=0: 0 cycles.
- Reset mid-accumulation: P returns to 0 asynchronously. The next accumulate after release starts from 0, not from the pre-reset value.
- Simultaneous ce_p=1 and X=P or Z=P: reads the old P and writes the new P (standard read-before-write).
- Outputs are never X after reset: all registers have defined reset values. Bypassed paths follow their inputs.

Optional Feature:
- Macro: POST_ADDER_PATTERN_DETECT_EN.
- Defined: adds parameter PATTERN (48'd0) and output `patterndetect` (1 bit). The signal is registered alongside P under ce_p and cleared by rst; it is 1 when the next P equals PATTERN. With PREG=0 it is combinational.
- Undefined: no port, no logic. The port list is exactly as above.

Test Plan:
1. Reset: drive rst=0 mid-run with P=48'h123 -> p=0, carryout=0 immediately, with no clk edge needed. After release, with ce_p=0, p stays 0.
2. Multiply-accumulate: opmode=6'b001001 (X=M, Z=P), m=36'd5, ce_p=1 for 4 cycles from P=0 -> p = 5, 10, 15, 20 on successive edges.
3. Subtract with borrow: opmode=6'b101111 (X=dab, Z=c, sub), c=48'd10, dab=48'd3 -> p=48'd7, carryout=0. Then dab=48'd11 -> p=48'hFFFF_FFFF_FFFF, carryout=1.
4. Overflow: X=dab=48'hFFFF_FFFF_FFFF, Z=c=48'd1, cin=1 -> p=48'd1, carryout=1.
5. Opmode latency: with OPMODEREG=1 and ce_opmode=1, switch X from M to dab -> p reflects dab one cycle later than with OPMODEREG=0. With ce_opmode=0, the switch has no effect.
6. Clock-enable hold: ce_p=0 while inputs change -> p, pcout and patterndetect are unchanged. With ce_carryout=0, carryout is unchanged even though carry toggles.
